// File: rtl/ariane_pkg.sv
// Shared execute-stage types: functional-unit operation codes and the
// per-instruction payload handed from issue to a functional unit.
package ariane_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    ADD, SUB, ANDL, ORL, XORL,
    EQ, NE, LTS, LTU, GES, GEU
  } fu_op;

  typedef struct packed {
    fu_op                     operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

endpackage

// File: rtl/alu_issue_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after
// rr_ptr_i, wrapping modulo NR_REQ; nothing is granted when en_i is low.
module alu_rr_arbiter #(
  parameter int unsigned NR_REQ = 2
) (
  input  logic [NR_REQ-1:0]         valid_i,
  input  logic                      en_i,
  input  logic [$clog2(NR_REQ)-1:0] rr_ptr_i,
  output logic [NR_REQ-1:0]         gnt_o,
  output logic [$clog2(NR_REQ)-1:0] idx_o,
  output logic                      any_o
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  int               cand_int;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    cand_int = 0;
    cand     = '0;
    found    = 1'b0;
    idx_o    = '0;
    gnt_o    = '0;
    for (int k = 0; k < int'(NR_REQ); k++) begin
      cand_int = (int'(rr_ptr_i) + k) % int'(NR_REQ);
      cand     = cand_int[IDX_W-1:0];
      if (!found && valid_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    any_o = found & en_i;
    if (any_o) begin
      gnt_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one combinational ALU between NR_REQ issue sources with round-robin
// arbitration and a single registered result stage drained by writeback.
module alu_issue_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ = 2,
  parameter int unsigned XLEN   = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NR_REQ-1:0]          req_valid_i,
  output logic [NR_REQ-1:0]          req_ready_o,
  input  fu_data_t                   req_data_i [NR_REQ],
  output fu_data_t                   alu_fu_data_o,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic                       alu_branch_res_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [XLEN-1:0]            result_o,
  output logic                       branch_res_o,
  output logic [TRANS_ID_BITS-1:0]   trans_id_o,
  output logic [$clog2(NR_REQ)-1:0]  src_o
);

  localparam int unsigned IDX_W = $clog2(NR_REQ);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the clock edge. Upstream holds valid/data until its ready bit is
  // seen; ready is a function of valid and output-register state only.
  // Downstream sees valid_o and the payload stable until ready_i is high.

  logic                     valid_q, valid_d;
  logic [XLEN-1:0]          result_q, result_d;
  logic                     branch_q, branch_d;
  logic [TRANS_ID_BITS-1:0] trans_id_q, trans_id_d;
  logic [IDX_W-1:0]         src_q, src_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;

  logic                     can_accept;
  logic [NR_REQ-1:0]        gnt;
  logic [IDX_W-1:0]         win_idx;
  logic                     win_any;

  // rst_ni in the enable keeps ready low throughout reset, not just after it.
  assign can_accept = rst_ni & ~flush_i & (~valid_q | ready_i);

  alu_rr_arbiter #(
    .NR_REQ (NR_REQ)
  ) u_rr (
    .valid_i  (req_valid_i),
    .en_i     (can_accept),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (gnt),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  assign req_ready_o   = gnt;
  assign alu_fu_data_o = win_any ? req_data_i[win_idx] : '0;

  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    branch_d   = branch_q;
    trans_id_d = trans_id_q;
    src_d      = src_q;
    rr_ptr_d   = rr_ptr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (win_any) begin
      valid_d    = 1'b1;
      result_d   = alu_result_i;
      branch_d   = alu_branch_res_i;
      trans_id_d = req_data_i[win_idx].trans_id;
      src_d      = win_idx;
      rr_ptr_d   = (win_idx == IDX_W'(NR_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      branch_q   <= 1'b0;
      trans_id_q <= '0;
      src_q      <= '0;
      rr_ptr_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      branch_q   <= branch_d;
      trans_id_q <= trans_id_d;
      src_q      <= src_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign valid_o      = valid_q;
  assign result_o     = result_q;
  assign branch_res_o = branch_q;
  assign trans_id_o   = trans_id_q;
  assign src_o        = src_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model of arbitration and the result slot.
module tb_alu_issue_arbiter;
  import ariane_pkg::*;

  localparam int NR = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     flush;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  fu_data_t                 req_data [NR];
  fu_data_t                 alu_data;
  logic [63:0]              alu_result;
  logic                     alu_branch;
  logic                     valid_out;
  logic                     ready;
  logic [63:0]              result_out;
  logic                     branch_out;
  logic [TRANS_ID_BITS-1:0] tid_out;
  logic [0:0]               src_out;

  alu_issue_arbiter #(.NR_REQ(NR), .XLEN(64)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_data_i       (req_data),
    .alu_fu_data_o    (alu_data),
    .alu_result_i     (alu_result),
    .alu_branch_res_i (alu_branch),
    .valid_o          (valid_out),
    .ready_i          (ready),
    .result_o         (result_out),
    .branch_res_o     (branch_out),
    .trans_id_o       (tid_out),
    .src_o            (src_out)
  );

  // behavioural ALU: {branch, result}
  function automatic logic [64:0] alu_fn(input fu_data_t d);
    logic [63:0] a, b;
    a = d.operand_a;
    b = d.operand_b;
    case (d.operation)
      ADD:     return {1'b0, a + b};
      SUB:     return {1'b0, a - b};
      ANDL:    return {1'b0, a & b};
      ORL:     return {1'b0, a | b};
      XORL:    return {1'b0, a ^ b};
      EQ:      return {(a == b), 63'd0, (a == b)};
      NE:      return {(a != b), 63'd0, (a != b)};
      LTS:     return {($signed(a) < $signed(b)), 63'd0, ($signed(a) < $signed(b))};
      LTU:     return {(a < b), 63'd0, (a < b)};
      GES:     return {($signed(a) >= $signed(b)), 63'd0, ($signed(a) >= $signed(b))};
      GEU:     return {(a >= b), 63'd0, (a >= b)};
      default: return 65'd0;
    endcase
  endfunction

  logic [64:0] alu_out;
  always_comb begin
    alu_out    = alu_fn(alu_data);
    alu_result = alu_out[63:0];
    alu_branch = alu_out[64];
  end

  function automatic fu_data_t mk(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [TRANS_ID_BITS-1:0] tid);
    fu_data_t d;
    d = '0;
    d.operation = op;
    d.operand_a = a;
    d.operand_b = b;
    d.trans_id  = tid;
    return d;
  endfunction

  // scoreboard state
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  logic                     m_valid;
  logic [63:0]              m_res;
  logic                     m_br;
  logic [TRANS_ID_BITS-1:0] m_tid;
  int                       m_src;
  int                       m_ptr;
  logic [NR-1:0]            last_rdy;
  logic [NR-1:0]            m_gnt;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_res   = '0;
    m_br    = 1'b0;
    m_tid   = '0;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one cycle: apply inputs, check same-cycle grant, advance, check output slot
  task automatic step(input logic [NR-1:0] v, input logic rdy, input logic fl);
    logic     can, w_any;
    int       w;
    fu_data_t exp_alu;
    logic [64:0] r;
    req_valid = v;
    ready     = rdy;
    flush     = fl;
    #1;
    can   = !fl && (!m_valid || rdy);
    w_any = 1'b0;
    w     = 0;
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (m_ptr + k) % NR;
      if (!w_any && v[c]) begin
        w_any = 1'b1;
        w     = c;
      end
    end
    m_gnt = '0;
    if (can && w_any) m_gnt[w] = 1'b1;
    last_rdy = req_ready;
    chk("req_ready", 256'(req_ready), 256'(m_gnt));
    exp_alu = (can && w_any) ? req_data[w] : '0;
    chk("alu_fu_data", 256'(alu_data), 256'(exp_alu));
    if (fl) begin
      m_valid = 1'b0;
    end else if (can && w_any) begin
      r       = alu_fn(req_data[w]);
      m_valid = 1'b1;
      m_res   = r[63:0];
      m_br    = r[64];
      m_tid   = req_data[w].trans_id;
      m_src   = w;
      m_ptr   = (w + 1) % NR;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    tick();
    chk("valid_o", 256'(valid_out), 256'(m_valid));
    if (m_valid) begin
      chk("result_o", 256'(result_out), 256'(m_res));
      chk("branch_res_o", 256'(branch_out), 256'(m_br));
      chk("trans_id_o", 256'(tid_out), 256'(m_tid));
      chk("src_o", 256'(src_out), 256'(m_src));
    end
  endtask

  logic          pend_v [NR];
  fu_data_t      pend_d [NR];
  logic [63:0]   ra;
  fu_op          rop;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    ready     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NR; i++) req_data[i] = '0;
    model_reset();

    // reset state, with requests asserted during reset
    #2;
    req_valid = 2'b11;
    req_data[0] = mk(ADD, 64'd1, 64'd2, 3'd1);
    ready = 1'b1;
    #1;
    chk("rst_ready", 256'(req_ready), 256'd0);
    tick();
    chk("rst_valid", 256'(valid_out), 256'd0);
    chk("rst_result", 256'(result_out), 256'd0);
    chk("rst_branch", 256'(branch_out), 256'd0);
    chk("rst_tid", 256'(tid_out), 256'd0);
    chk("rst_src", 256'(src_out), 256'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // single ADD from requester 0
    req_data[0] = mk(ADD, 64'd5, 64'd7, 3'd3);
    step(2'b01, 1'b1, 1'b0);
    chk("t1_ready", 256'(last_rdy), 256'(2'b01));
    chk("t1_result", 256'(result_out), 256'd12);
    chk("t1_tid", 256'(tid_out), 256'd3);
    chk("t1_src", 256'(src_out), 256'd0);

    // requester 1 alone moves the pointer back to 0
    req_data[1] = mk(ADD, 64'd0, 64'd0, 3'd0);
    step(2'b10, 1'b1, 1'b0);

    // alternating grants: 0,1,0,1
    req_data[0] = mk(ADD, 64'd1, 64'd1, 3'd1);
    req_data[1] = mk(SUB, 64'd9, 64'd4, 3'd2);
    exp_q = {64'd2, 64'd5, 64'd2, 64'd5};
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b1, 1'b0);
      chk("t2_result", 256'(result_out), 256'(exp_q.pop_front()));
      chk("t2_src", 256'(src_out), 256'(i % 2));
    end

    // stall with ready low, then drain+grant in one cycle
    step(2'b11, 1'b1, 1'b0);
    chk("t3_first", 256'(result_out), 256'd2);
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b0, 1'b0);
      chk("t3_stall_ready", 256'(last_rdy), 256'd0);
      chk("t3_stall_valid", 256'(valid_out), 256'd1);
      chk("t3_stall_result", 256'(result_out), 256'd2);
    end
    step(2'b11, 1'b1, 1'b0);
    chk("t3_drain_ready", 256'(last_rdy), 256'(2'b10));
    chk("t3_next_result", 256'(result_out), 256'd5);

    // branch compare results
    req_data[1] = mk(EQ, 64'd8, 64'd8, 3'd4);
    step(2'b10, 1'b1, 1'b0);
    chk("t4_eq", 256'(branch_out), 256'd1);
    req_data[1] = mk(NE, 64'd8, 64'd8, 3'd5);
    step(2'b10, 1'b1, 1'b0);
    chk("t4_ne", 256'(branch_out), 256'd0);

    // flush while holding a result: no grant, pointer unchanged (still 0)
    step(2'b11, 1'b1, 1'b1);
    chk("t5_ready", 256'(last_rdy), 256'd0);
    chk("t5_valid", 256'(valid_out), 256'd0);
    step(2'b11, 1'b1, 1'b0);
    chk("t5_ptr", 256'(src_out), 256'd0);

    // asynchronous reset mid-cycle with a result held
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 256'(valid_out), 256'd0);
    chk("t6_async_ready", 256'(req_ready), 256'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    step(2'b11, 1'b1, 1'b0);
    chk("t6_first_src", 256'(src_out), 256'd0);
    step(2'b00, 1'b1, 1'b0);

    // randomized traffic: requests held until granted
    for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [NR-1:0] v;
      for (int i = 0; i < NR; i++) begin
        if (!pend_v[i] && $urandom_range(0, 99) < 60) begin
          ra  = {$urandom, $urandom};
          rop = fu_op'($urandom_range(0, 10));
          pend_d[i] = mk(rop, ra,
                         ($urandom_range(0, 2) == 0) ? ra : {$urandom, $urandom},
                         3'($urandom_range(0, 7)));
          pend_v[i] = 1'b1;
        end
        req_data[i] = pend_d[i];
        v[i] = pend_v[i];
      end
      step(v, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      for (int i = 0; i < NR; i++) if (m_gnt[i]) pend_v[i] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
